alu_issue_stage: RTL and testbench

Decode/issue stage that sits directly upstream of the 32-bit integer ALU. It accepts RV32I OP-IMM and OP instructions over a valid/ready handshake and reads operands from an internal 32x32 register file. It produces the registered 6-bit ALU opcode and both operands for the ALU. A per-register pending scoreboard stalls issue until an outstanding result returns on the writeback port.

---
 rtl/alu_issue_stage_if.sv | 30 +++
 rtl/alu_issue_stage.sv | 141 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the instruction source, the issue stage and the ALU.
// The master drives instructions, writebacks and ex_ready; the slave is the issue stage.
interface alu_issue_stage_if #(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 6
);
  logic               instr_valid;
  logic [31:0]        instr;
  logic               instr_ready;
  logic               wb_en;
  logic [4:0]         wb_rd;
  logic [WIDTH-1:0]   wb_data;
  logic               ex_valid;
  logic               ex_ready;
  logic [OPWIDTH-1:0] ex_op;
  logic [WIDTH-1:0]   ex_in1;
  logic [WIDTH-1:0]   ex_in2;
  logic [4:0]         ex_rd;
  logic               illegal;

  modport master (
    output instr_valid, instr, wb_en, wb_rd, wb_data, ex_ready,
    input  instr_ready, ex_valid, ex_op, ex_in1, ex_in2, ex_rd, illegal
  );

  modport slave (
    input  instr_valid, instr, wb_en, wb_rd, wb_data, ex_ready,
    output instr_ready, ex_valid, ex_op, ex_in1, ex_in2, ex_rd, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decode and issue stage: register file, pending scoreboard,
// hazard stall and a one-entry output register feeding the ALU.
module alu_issue_stage (
  input  logic               clk,
  input  logic               reset,
  alu_issue_stage_if.slave   bus
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [31:0] r_rf [32];
  logic [31:0] r_pend;
  logic        r_ex_valid;
  logic [5:0]  r_ex_op;
  logic [31:0] r_ex_in1;
  logic [31:0] r_ex_in2;
  logic [4:0]  r_ex_rd;
  logic        r_illegal;

  logic [6:0]  w_opc;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_is_op;
  logic        w_is_imm;
  logic        w_is_shift;
  logic        w_legal;
  logic [5:0]  w_op;
  logic        w_wb_hit1;
  logic        w_wb_hit2;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_in2;
  logic        w_hazard;
  logic        w_ready;
  logic        w_accept;
  logic        w_issue;
  logic [31:0] w_pend_nxt;

  assign w_opc = bus.instr[6:0];
  assign w_rd  = bus.instr[11:7];
  assign w_f3  = bus.instr[14:12];
  assign w_rs1 = bus.instr[19:15];
  assign w_rs2 = bus.instr[24:20];
  assign w_f7  = bus.instr[31:25];

  assign w_is_op    = (w_opc == OPC_OP);
  assign w_is_imm   = (w_opc == OPC_IMM);
  assign w_is_shift = w_is_imm && (w_f3 == 3'b001 || w_f3 == 3'b101);

  always_comb begin
    w_legal = 1'b0;
    if (w_is_imm) begin
      case (w_f3)
        3'b001:  w_legal = (w_f7 == 7'd0);
        3'b101:  w_legal = (w_f7 == 7'd0) || (w_f7 == F7_ALT);
        default: w_legal = 1'b1;
      endcase
    end else if (w_is_op) begin
      w_legal = (w_f7 == 7'd0) ||
                ((w_f7 == F7_ALT) && (w_f3 == 3'b000 || w_f3 == 3'b101));
    end
  end

  assign w_op = {(w_is_op || w_is_shift) & bus.instr[30], w_f3, 1'b0, w_is_op};

  // Writeback in the same cycle bypasses the register file.
  assign w_wb_hit1 = bus.wb_en && (bus.wb_rd == w_rs1);
  assign w_wb_hit2 = bus.wb_en && (bus.wb_rd == w_rs2);

  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != 5'd0) w_rs1_val = w_wb_hit1 ? bus.wb_data : r_rf[w_rs1];
    if (w_rs2 != 5'd0) w_rs2_val = w_wb_hit2 ? bus.wb_data : r_rf[w_rs2];
  end

  always_comb begin
    if (w_is_op)         w_in2 = w_rs2_val;
    else if (w_is_shift) w_in2 = {27'd0, w_rs2};
    else                 w_in2 = {{20{bus.instr[31]}}, bus.instr[31:20]};
  end

  // Illegal words are dropped, so they never wait on the scoreboard.
  assign w_hazard = w_legal &&
                    ((r_pend[w_rs1] && !w_wb_hit1) ||
                     (w_is_op && r_pend[w_rs2] && !w_wb_hit2));
  assign w_ready  = !w_hazard && (!r_ex_valid || bus.ex_ready);
  assign w_accept = bus.instr_valid && w_ready;
  assign w_issue  = w_accept && w_legal;

  always_comb begin
    w_pend_nxt = r_pend;
    if (bus.wb_en) w_pend_nxt[bus.wb_rd] = 1'b0;
    if (w_issue)   w_pend_nxt[w_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_in1   <= '0;
      r_ex_in2   <= '0;
      r_ex_rd    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_illegal <= w_accept && !w_legal;
      if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= w_op;
        r_ex_in1   <= w_rs1_val;
        r_ex_in2   <= w_in2;
        r_ex_rd    <= w_rd;
      end else if (bus.ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_op       = r_ex_op;
  assign bus.ex_in1      = r_ex_in1;
  assign bus.ex_in2      = r_ex_in2;
  assign bus.ex_rd       = r_ex_rd;
  assign bus.illegal     = r_illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed corner sequences, a decode vector table,
// and randomized traffic against an instruction-level reference model.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();
  alu_issue_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic [5:0]  op;
    logic [31:0] in2;
  } vec_t;
  vec_t tbl[17];

  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_exv, m_ill;
  logic [5:0]  m_op;
  logic [31:0] m_in1, m_in2;
  logic [4:0]  m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.wb_en       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    bus.ex_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic chk_ex(input string tag, input logic [5:0] op, input logic [31:0] in1,
                        input logic [31:0] in2, input logic [4:0] rd);
    chk({tag, "_valid"}, bus.ex_valid, 1'b1);
    chk({tag, "_op"}, bus.ex_op, op);
    chk({tag, "_in1"}, bus.ex_in1, in1);
    chk({tag, "_in2"}, bus.ex_in2, in2);
    chk({tag, "_rd"}, bus.ex_rd, rd);
  endtask

  task automatic send(input logic [31:0] w);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
  endtask

  // Reference model: instruction semantics straight from the ISA rules.
  function automatic bit m_is_legal(input logic [31:0] w);
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    if (opc == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
      return 1'b1;
    end
    if (opc == 7'h33) return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
    return m_rf[r];
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return m_pend[r] && !(bus.wb_en && bus.wb_rd == r);
  endfunction

  function automatic logic [31:0] gen_instr();
    int kind = $urandom_range(0, 9);
    int sel  = $urandom_range(0, 3);
    logic [6:0] opc, f7;
    logic [2:0] f3  = 3'($urandom_range(0, 7));
    logic [4:0] rs1 = 5'($urandom_range(0, 7));
    logic [4:0] rs2 = 5'($urandom_range(0, 7));
    logic [4:0] rd  = 5'($urandom_range(0, 7));
    if (kind < 4)      opc = 7'h13;
    else if (kind < 8) opc = 7'h33;
    else               opc = 7'($urandom);
    if (sel == 0)      f7 = 7'h00;
    else if (sel < 3)  f7 = 7'h20;
    else               f7 = 7'($urandom);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic model_step();
    logic [31:0] w = bus.instr;
    bit is_op    = (w[6:0] == 7'h33);
    bit is_shift = (w[6:0] == 7'h13) && (w[14:12] == 3'd1 || w[14:12] == 3'd5);
    bit legal    = m_is_legal(w);
    bit haz      = legal && (m_busy(w[19:15]) || (is_op && m_busy(w[24:20])));
    bit exp_rdy  = !haz && (!m_exv || bus.ex_ready);
    bit acc      = bus.instr_valid && exp_rdy;
    int op_val;
    chk("rnd_ready", bus.instr_ready, exp_rdy);
    if (acc && legal) begin
      op_val = int'(w[14:12]) * 4 + (is_op ? 1 : 0) + ((w[30] && (is_op || is_shift)) ? 32 : 0);
      m_exv = 1'b1;
      m_op  = 6'(op_val);
      m_in1 = m_read(w[19:15]);
      if (is_op)         m_in2 = m_read(w[24:20]);
      else if (is_shift) m_in2 = 32'(w[24:20]);
      else               m_in2 = 32'($signed(w[31:20]));
      m_rd  = w[11:7];
    end else if (bus.ex_ready) begin
      m_exv = 1'b0;
    end
    m_ill = acc && !legal;
    if (bus.wb_en) m_pend[bus.wb_rd] = 1'b0;
    if (acc && legal && w[11:7] != 5'd0) m_pend[w[11:7]] = 1'b1;
    if (bus.wb_en && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] = bus.wb_data;
  endtask

  initial begin
    tbl[0]  = '{32'h00500013, 1'b1, 6'b000000, 32'h00000005};
    tbl[1]  = '{32'hFFF00013, 1'b1, 6'b000000, 32'hFFFFFFFF};
    tbl[2]  = '{32'h80002013, 1'b1, 6'b001000, 32'hFFFFF800};
    tbl[3]  = '{32'h7FF04013, 1'b1, 6'b010000, 32'h000007FF};
    tbl[4]  = '{32'h40000013, 1'b1, 6'b000000, 32'h00000400};
    tbl[5]  = '{32'h01F01013, 1'b1, 6'b000100, 32'h0000001F};
    tbl[6]  = '{32'h41F01013, 1'b0, 6'b000000, 32'h00000000};
    tbl[7]  = '{32'h00705013, 1'b1, 6'b010100, 32'h00000007};
    tbl[8]  = '{32'h40405013, 1'b1, 6'b110100, 32'h00000004};
    tbl[9]  = '{32'h02305013, 1'b0, 6'b000000, 32'h00000000};
    tbl[10] = '{32'h00000033, 1'b1, 6'b000001, 32'h00000000};
    tbl[11] = '{32'h40000033, 1'b1, 6'b100001, 32'h00000000};
    tbl[12] = '{32'h40005033, 1'b1, 6'b110101, 32'h00000000};
    tbl[13] = '{32'h40006033, 1'b0, 6'b000000, 32'h00000000};
    tbl[14] = '{32'h02000033, 1'b0, 6'b000000, 32'h00000000};
    tbl[15] = '{32'h00007033, 1'b1, 6'b011101, 32'h00000000};
    tbl[16] = '{32'h00000037, 1'b0, 6'b000000, 32'h00000000};

    // Reset state, then ADDI x1,x0,5
    do_reset();
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ex_op", bus.ex_op, 6'd0);
    chk("rst_ex_in1", bus.ex_in1, 32'd0);
    chk("rst_ex_in2", bus.ex_in2, 32'd0);
    chk("rst_ex_rd", bus.ex_rd, 5'd0);
    chk("rst_illegal", bus.illegal, 1'b0);
    send(32'h00500093);
    #1 chk("addi_ready", bus.instr_ready, 1'b1);
    cyc();
    idle();
    chk_ex("addi", 6'b000000, 32'd0, 32'd5, 5'd1);

    // ADD x2,x1,x1 stalls on pending x1 until writeback, accepted via bypass
    send(32'h00108133);
    #1 chk("raw_stall0", bus.instr_ready, 1'b0);
    cyc();
    chk("raw_drain_valid", bus.ex_valid, 1'b0);
    chk("raw_stall1", bus.instr_ready, 1'b0);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
    #1 chk("raw_wb_ready", bus.instr_ready, 1'b1);
    cyc();
    idle();
    chk_ex("add_bypass", 6'b000001, 32'd5, 32'd5, 5'd2);

    // Backpressure: ex_* held for 3 cycles, then ADDI x3,x0,7 issues
    bus.ex_ready = 1'b0;
    send(32'h00700193);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", bus.instr_ready, 1'b0);
      cyc();
      chk_ex("bp_hold", 6'b000001, 32'd5, 32'd5, 5'd2);
    end
    bus.ex_ready = 1'b1;
    #1 chk("bp_release_ready", bus.instr_ready, 1'b1);
    cyc();
    idle();
    chk_ex("bp_next", 6'b000000, 32'd0, 32'd7, 5'd3);

    // x3 = 0x80000000, then SRAI x4,x3,4
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h80000000;
    cyc();
    idle();
    send(32'h4041D213);
    #1 chk("srai_ready", bus.instr_ready, 1'b1);
    cyc();
    idle();
    chk_ex("srai", 6'b110100, 32'h80000000, 32'd4, 5'd4);

    // MUL x6 is illegal: one-cycle pulse, no issue, x6 not marked pending
    send(32'h02000333);
    #1 chk("mul_ready", bus.instr_ready, 1'b1);
    cyc();
    chk("mul_illegal", bus.illegal, 1'b1);
    chk("mul_ex_valid", bus.ex_valid, 1'b0);
    send(32'h000303B3);
    #1 chk("mul_no_pend", bus.instr_ready, 1'b1);
    cyc();
    idle();
    chk("mul_pulse_end", bus.illegal, 1'b0);
    chk("add_x7_valid", bus.ex_valid, 1'b1);
    chk("add_x7_rd", bus.ex_rd, 5'd7);

    // Writes to x0 are ignored, including the bypass path
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    cyc();
    send(32'h000002B3);
    cyc();
    idle();
    chk_ex("x0_read", 6'b000001, 32'd0, 32'd0, 5'd5);

    // Reset while holding an instruction clears outputs, regs and scoreboard
    send(32'h00500093);
    cyc();
    idle();
    chk("pre_rst_valid", bus.ex_valid, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_valid", bus.ex_valid, 1'b0);
    chk("mid_rst_op", bus.ex_op, 6'd0);
    chk("mid_rst_in1", bus.ex_in1, 32'd0);
    chk("mid_rst_in2", bus.ex_in2, 32'd0);
    chk("mid_rst_rd", bus.ex_rd, 5'd0);
    send(32'h00108133);
    #1 chk("post_rst_no_pend", bus.instr_ready, 1'b1);
    cyc();
    idle();
    chk_ex("post_rst_regs", 6'b000001, 32'd0, 32'd0, 5'd2);

    // Decode vector table (rd=rs1=rs2=x0, so no scoreboard interaction)
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].instr);
      #1 chk($sformatf("tbl%0d_ready", i), bus.instr_ready, 1'b1);
      cyc();
      idle();
      chk($sformatf("tbl%0d_valid", i), bus.ex_valid, tbl[i].legal);
      chk($sformatf("tbl%0d_illegal", i), bus.illegal, !tbl[i].legal);
      if (tbl[i].legal) begin
        chk($sformatf("tbl%0d_op", i), bus.ex_op, tbl[i].op);
        chk($sformatf("tbl%0d_in1", i), bus.ex_in1, 32'd0);
        chk($sformatf("tbl%0d_in2", i), bus.ex_in2, tbl[i].in2);
      end
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_exv = 1'b0; m_ill = 1'b0; m_op = '0; m_in1 = '0; m_in2 = '0; m_rd = '0;
    for (int c = 0; c < 800; c++) begin
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.instr       = gen_instr();
      bus.ex_ready    = ($urandom_range(0, 3) != 0);
      bus.wb_en       = ($urandom_range(0, 1) != 0);
      bus.wb_rd       = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      #1;
      model_step();
      cyc();
      chk("rnd_ex_valid", bus.ex_valid, m_exv);
      chk("rnd_illegal", bus.illegal, m_ill);
      if (m_exv) begin
        chk("rnd_op", bus.ex_op, m_op);
        chk("rnd_in1", bus.ex_in1, m_in1);
        chk("rnd_in2", bus.ex_in2, m_in2);
        chk("rnd_rd", bus.ex_rd, m_rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
